// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, per-scan classification,
// press/release debounce and a one-cycle strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] col_sense,
  output logic [3:0] row_drive,
  output logic       strobe,
  output logic [7:0] cur_key,
  output logic       key_down,
  output logic       multi_key
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [3:0]    r_col_meta, r_col_sync;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [11:0]   r_scan;
  logic          r_res_valid, r_res_none, r_res_single, r_multi_key;
  logic [7:0]    r_res_key;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_cand, r_cur_key;
  logic          r_strobe, r_key_down;

  logic          w_last_dwell;
  logic [15:0]   w_rows;
  logic [4:0]    w_ones;
  logic [7:0]    w_key;

  assign w_last_dwell = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_rows       = {r_scan, r_col_sync};

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_ones = '0;
    w_key  = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_rows[i]) begin
        w_ones = w_ones + 5'd1;
        w_key  = w_key | (8'h10 << (i / 4)) | (8'h01 << (i % 4));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_meta <= '0;
      r_col_sync <= '0;
    end else begin
      r_col_meta <= col_sense;
      r_col_sync <= r_col_meta;
    end
  end

  // The 2-cycle synchronizer lag still lands inside the dwell, so the last
  // dwell cycle sees columns captured while the current row was driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell      <= '0;
      r_row        <= '0;
      r_scan       <= '0;
      r_res_valid  <= 1'b0;
      r_res_none   <= 1'b0;
      r_res_single <= 1'b0;
      r_res_key    <= '0;
      r_multi_key  <= 1'b0;
    end else if (!en) begin
      r_dwell     <= '0;
      r_row       <= '0;
      r_res_valid <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_multi_key <= 1'b0;
      if (w_last_dwell) begin
        r_dwell <= '0;
        r_row   <= r_row + 2'd1;
        case (r_row)
          2'd0: r_scan[11:8] <= r_col_sync;
          2'd1: r_scan[7:4]  <= r_col_sync;
          2'd2: r_scan[3:0]  <= r_col_sync;
          default: begin
            r_res_valid  <= 1'b1;
            r_res_none   <= (w_ones == 5'd0);
            r_res_single <= (w_ones == 5'd1);
            r_res_key    <= w_key;
            r_multi_key  <= (w_ones > 5'd1);
          end
        endcase
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RELEASED;
      r_cnt      <= '0;
      r_cand     <= '0;
      r_strobe   <= 1'b0;
      r_cur_key  <= '0;
      r_key_down <= 1'b0;
    end else if (!en) begin
      r_state    <= RELEASED;
      r_cnt      <= '0;
      r_strobe   <= 1'b0;
      r_key_down <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_res_valid) begin
        case (r_state)
          RELEASED: begin
            if (r_res_single) begin
              r_cand <= r_res_key;
              if (DEBOUNCE_SCANS == 1) begin
                r_state    <= PRESSED;
                r_cnt      <= '0;
                r_cur_key  <= r_res_key;
                r_key_down <= 1'b1;
                r_strobe   <= 1'b1;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= PRESS_WAIT;
              end
            end
          end
          PRESS_WAIT: begin
            if (r_res_single && r_res_key == r_cand) begin
              if (r_cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                r_state    <= PRESSED;
                r_cnt      <= '0;
                r_cur_key  <= r_cand;
                r_key_down <= 1'b1;
                r_strobe   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else if (r_res_single) begin
              r_cand <= r_res_key;
              r_cnt  <= 4'd1;
            end else begin
              r_state <= RELEASED;
              r_cnt   <= '0;
            end
          end
          PRESSED: begin
            if (r_res_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                r_state    <= RELEASED;
                r_cnt      <= '0;
                r_key_down <= 1'b0;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= RELEASE_WAIT;
              end
            end
          end
          RELEASE_WAIT: begin
            if (!r_res_none) begin
              r_state <= PRESSED;
              r_cnt   <= '0;
            end else if (r_cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              r_state    <= RELEASED;
              r_cnt      <= '0;
              r_key_down <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: r_state <= RELEASED;
        endcase
      end
    end
  end

  assign row_drive = en ? (4'b1000 >> r_row) : 4'b0000;
  assign strobe    = r_strobe;
  assign cur_key   = r_cur_key;
  assign key_down  = r_key_down;
  assign multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, a per-scan behavioural
// debounce model checked every cycle, and directed press scenarios.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int PERIOD   = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b1;
  logic [15:0] keys = '0;   // [15:12]=R0 (bit15=C0) .. [3:0]=R3
  logic [3:0]  col_sense;
  logic [3:0]  row_drive;
  logic        strobe, key_down, multi_key;
  logic [7:0]  cur_key;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .en(en), .col_sense(col_sense),
    .row_drive(row_drive), .strobe(strobe), .cur_key(cur_key),
    .key_down(key_down), .multi_key(multi_key)
  );

  // Pressed keys short their row to their column.
  assign col_sense = ({4{row_drive[3]}} & keys[15:12]) | ({4{row_drive[2]}} & keys[11:8])
                   | ({4{row_drive[1]}} & keys[7:4])   | ({4{row_drive[0]}} & keys[3:0]);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle index since the scanner last restarted at R0.
  int   cyc;
  logic en_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc  <= 0;
      en_d <= 1'b0;
    end else begin
      cyc  <= en ? cyc + 1 : 0;
      en_d <= en;
    end
  end

  // Behavioural model state.
  logic        chk_on = 1'b0;
  logic [15:0] scan_pat = '0, done_pat = '0;
  logic        held = 1'b0;
  int          run_len = 0, none_run = 0;
  logic [7:0]  run_key = '0, exp_cur_key = '0;
  int          n_strobe = 0, strobe_cyc = -1, n_multi = 0;
  int          ph;
  logic [3:0]  exp_row;
  logic [3:0]  row_one = 4'b1000;
  logic        exp_strobe, exp_multi;

  function automatic int classify(input logic [15:0] p);
    if (p == 16'h0) return 0;
    if ($countones(p) == 1) return 1;
    return 2;
  endfunction

  function automatic logic [7:0] code_of(input logic [15:0] p);
    logic [3:0] one;
    logic [7:0] code;
    one  = 4'b1000;
    code = '0;
    for (int b = 0; b < 16; b++)
      if (p[b]) code = {one >> ((15 - b) / 4), one >> ((15 - b) % 4)};
    return code;
  endfunction

  task automatic model_step(input logic [15:0] p, output logic stb);
    int k;
    stb = 1'b0;
    k   = classify(p);
    if (!held) begin
      if (k == 1) begin
        if (run_len > 0 && run_key == code_of(p)) run_len++;
        else begin
          run_len = 1;
          run_key = code_of(p);
        end
        if (run_len >= DEB) begin
          held        = 1'b1;
          run_len     = 0;
          none_run    = 0;
          exp_cur_key = run_key;
          stb         = 1'b1;
        end
      end else run_len = 0;
    end else if (k == 0) begin
      none_run++;
      if (none_run >= DEB) begin
        held     = 1'b0;
        none_run = 0;
      end
    end else none_run = 0;
  endtask

  // Compare process: mid-cycle, every cycle.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      ph         = cyc % PERIOD;
      exp_strobe = 1'b0;
      exp_multi  = 1'b0;
      if (rst) begin
        held = 1'b0; run_len = 0; none_run = 0; exp_cur_key = '0;
      end else if (!en) begin
        held = 1'b0; run_len = 0; none_run = 0;
      end else begin
        if (ph == 0) begin
          if (cyc >= PERIOD) begin
            done_pat  = scan_pat;
            exp_multi = (classify(done_pat) == 2);
          end
          scan_pat = keys;
        end
        if (ph == 1 && cyc > PERIOD) model_step(done_pat, exp_strobe);
      end
      exp_row = en ? (row_one >> (ph / SCAN_DIV)) : 4'b0000;
      check("row_drive", row_drive, exp_row);
      check("cur_key", cur_key, exp_cur_key);
      if (en || !en_d) begin
        check("strobe", strobe, exp_strobe);
        check("key_down", key_down, held);
        check("multi_key", multi_key, exp_multi);
      end
      if (strobe) begin
        n_strobe++;
        strobe_cyc = cyc;
      end
      if (multi_key) n_multi++;
    end
  end

  // Advance to #1 after the edge that starts the next phase-0 cycle.
  task automatic sync0();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (cyc % PERIOD != 0 && k < 3 * PERIOD);
    if (cyc % PERIOD != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sync0_timeout: no scan start within %0d cycles", k);
    end
  endtask

  task automatic press(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      sync0();
      keys = pat;
    end
  endtask

  task automatic settle();
    sync0();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    return 16'h8000 >> (4 * r + c);
  endfunction

  initial begin
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_drive", row_drive, 4'b1000);
    check("rst_strobe", strobe, 1'b0);
    check("rst_cur_key", cur_key, 8'h00);
    check("rst_key_down", key_down, 1'b0);
    check("rst_multi_key", multi_key, 1'b0);
    rst = 1'b0;

    // Scan order R0..R3, repeating every 16 cycles.
    repeat (5) @(posedge clk); #1;
    check("scan_c5_R1", row_drive, 4'b0100);
    repeat (8) @(posedge clk); #1;
    check("scan_c13_R3", row_drive, 4'b0001);
    repeat (8) @(posedge clk); #1;
    check("scan_c21_R1", row_drive, 4'b0100);

    // Stable R3C0 press: scans start at cycle 32, strobe after the 3rd result.
    n_strobe = 0;
    press(key(3, 0), 6);
    check("t2_strobes", n_strobe, 1);
    check("t2_strobe_cyc", strobe_cyc, 81);
    check("t2_cur_key", cur_key, 8'h18);
    check("t2_key_down", key_down, 1'b1);
    press(16'h0, 3);
    settle();
    check("t2_rel_key_down", key_down, 1'b0);
    check("t2_rel_cur_key", cur_key, 8'h18);
    check("t2_rel_strobes", n_strobe, 1);

    // Bouncy R2C0: press, none, press x3.
    n_strobe = 0;
    press(key(2, 0), 1);
    press(16'h0, 1);
    press(key(2, 0), 3);
    settle();
    check("t3_strobes", n_strobe, 1);
    check("t3_cur_key", cur_key, 8'h28);
    press(16'h0, 3);
    settle();

    // R0C0+R1C3 together, then R1C3 released.
    n_strobe = 0;
    n_multi  = 0;
    press(key(0, 0) | key(1, 3), 3);
    press(key(0, 0), 3);
    settle();
    check("t4_multi_pulses", n_multi, 3);
    check("t4_strobes", n_strobe, 1);
    check("t4_cur_key", cur_key, 8'h88);
    press(16'h0, 3);
    settle();

    // Key change while held is ignored until release.
    n_strobe = 0;
    press(key(3, 1), 3);
    press(key(2, 3), 3);
    settle();
    check("t5_held_strobes", n_strobe, 1);
    check("t5_held_cur_key", cur_key, 8'h14);
    press(16'h0, 3);
    press(key(2, 3), 3);
    settle();
    check("t5_strobes", n_strobe, 2);
    check("t5_cur_key", cur_key, 8'h21);
    press(16'h0, 3);
    settle();

    // Reset during PRESS_WAIT.
    n_strobe = 0;
    press(key(1, 1), 2);
    sync0();
    repeat (6) @(posedge clk); #1;
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    press(16'h0, 4);
    settle();
    check("t6_rst_strobes", n_strobe, 0);
    check("t6_rst_cur_key", cur_key, 8'h00);
    check("t6_rst_key_down", key_down, 1'b0);

    // en dropped during PRESS_WAIT, key kept held.
    press(key(3, 0), 3);
    press(16'h0, 3);
    settle();
    n_strobe = 0;
    press(key(1, 1), 2);
    sync0();
    repeat (6) @(posedge clk); #1;
    en = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("t6_en_row_drive", row_drive, 4'b0000);
    check("t6_en_cur_key", cur_key, 8'h18);
    check("t6_en_key_down", key_down, 1'b0);
    check("t6_en_strobes", n_strobe, 0);
    en = 1'b1;
    #1;
    check("t6_restart_R0", row_drive, 4'b1000);
    repeat (52) @(posedge clk); #1;
    check("t6_re_strobes", n_strobe, 1);
    check("t6_re_strobe_cyc", strobe_cyc, 49);
    check("t6_re_cur_key", cur_key, 8'h44);
    press(16'h0, 3);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
